// File: rtl/countdown_timer.sv
// Down-counting MM:SS.cc timer on the 100 Hz time base. Loads a saturated preset,
// counts toward zero in RUN and flags expiry. The display can be held while counting continues.
module countdown_timer #(
  parameter int MAX_MINS      = 99,
  parameter int TICKS_PER_DEC = 1
) (
  input  logic       CLK_100Hz,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] load_mins,
  input  logic [5:0] load_secs,
  input  logic [6:0] load_decs,
  input  logic       start_stop,
  input  logic       hold,
  output logic [6:0] timer_unit_mins,
  output logic [5:0] timer_unit_secs,
  output logic [6:0] timer_unit_decs,
  output logic       timer_running,
  output logic       timer_expired,
  output logic       timer_expired_pulse
);

  localparam int         PW      = (TICKS_PER_DEC > 1) ? $clog2(TICKS_PER_DEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_DEC - 1);
  localparam logic [6:0] MAX_M   = 7'(MAX_MINS);
  localparam logic [5:0] MAX_S   = 6'd59;
  localparam logic [6:0] MAX_D   = 7'd99;

  typedef enum logic [1:0] {IDLE, PAUSED, RUN, EXPIRED} state_t;

  state_t          state_reg, state_next;
  logic [6:0]      mins_reg, mins_next;
  logic [5:0]      secs_reg, secs_next;
  logic [6:0]      decs_reg, decs_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [6:0]      disp_mins_reg, disp_mins_next;
  logic [5:0]      disp_secs_reg, disp_secs_next;
  logic [6:0]      disp_decs_reg, disp_decs_next;
  logic            running_reg, running_next;
  logic            expired_reg, expired_next;
  logic            pulse_reg, pulse_next;

  always_ff @(posedge CLK_100Hz) begin
    if (reset) begin
      state_reg     <= IDLE;
      mins_reg      <= '0;
      secs_reg      <= '0;
      decs_reg      <= '0;
      presc_reg     <= '0;
      disp_mins_reg <= '0;
      disp_secs_reg <= '0;
      disp_decs_reg <= '0;
      running_reg   <= 1'b0;
      expired_reg   <= 1'b0;
      pulse_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mins_reg      <= mins_next;
      secs_reg      <= secs_next;
      decs_reg      <= decs_next;
      presc_reg     <= presc_next;
      disp_mins_reg <= disp_mins_next;
      disp_secs_reg <= disp_secs_next;
      disp_decs_reg <= disp_decs_next;
      running_reg   <= running_next;
      expired_reg   <= expired_next;
      pulse_reg     <= pulse_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mins_next    = mins_reg;
    secs_next    = secs_reg;
    decs_next    = decs_reg;
    presc_next   = presc_reg;
    expired_next = expired_reg;
    pulse_next   = 1'b0;

    if (load && state_reg != RUN) begin
      mins_next    = (load_mins > MAX_M) ? MAX_M : load_mins;
      secs_next    = (load_secs > MAX_S) ? MAX_S : load_secs;
      decs_next    = (load_decs > MAX_D) ? MAX_D : load_decs;
      presc_next   = '0;
      expired_next = 1'b0;
      state_next   = (mins_next != 0 || secs_next != 0 || decs_next != 0) ? PAUSED : IDLE;
    end else begin
      case (state_reg)
        PAUSED: if (start_stop) state_next = RUN;
        RUN: begin
          if (!start_stop) begin
            // Pausing keeps the partial prescaler count so resume timing is seamless.
            state_next = PAUSED;
          end else if (presc_reg == PRESC_LAST) begin
            presc_next = '0;
            if (decs_reg != 0) begin
              decs_next = decs_reg - 7'd1;
            end else if (secs_reg != 0) begin
              decs_next = MAX_D;
              secs_next = secs_reg - 6'd1;
            end else begin
              decs_next = MAX_D;
              secs_next = MAX_S;
              mins_next = mins_reg - 7'd1;
            end
            if (mins_next == 0 && secs_next == 0 && decs_next == 0) begin
              state_next   = EXPIRED;
              expired_next = 1'b1;
              pulse_next   = 1'b1;
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Display tracks the freshly updated count unless held; expiry flags bypass hold.
  always_comb begin
    disp_mins_next = disp_mins_reg;
    disp_secs_next = disp_secs_reg;
    disp_decs_next = disp_decs_reg;
    if (!hold) begin
      disp_mins_next = mins_next;
      disp_secs_next = secs_next;
      disp_decs_next = decs_next;
    end
    running_next = (state_next == RUN);
  end

  assign timer_unit_mins     = disp_mins_reg;
  assign timer_unit_secs     = disp_secs_reg;
  assign timer_unit_decs     = disp_decs_reg;
  assign timer_running       = running_reg;
  assign timer_expired       = expired_reg;
  assign timer_expired_pulse = pulse_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues cycle-stamped expectations,
// a monitor pops and compares them just after each rising edge.
module tb_countdown_timer;

  logic       CLK_100Hz = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [6:0] load_mins = '0;
  logic [5:0] load_secs = '0;
  logic [6:0] load_decs = '0;
  logic       start_stop = 1'b0;
  logic       hold = 1'b0;
  logic [6:0] timer_unit_mins;
  logic [5:0] timer_unit_secs;
  logic [6:0] timer_unit_decs;
  logic       timer_running;
  logic       timer_expired;
  logic       timer_expired_pulse;

  countdown_timer #(.MAX_MINS(99), .TICKS_PER_DEC(1)) dut (
    .CLK_100Hz(CLK_100Hz), .reset(reset), .load(load),
    .load_mins(load_mins), .load_secs(load_secs), .load_decs(load_decs),
    .start_stop(start_stop), .hold(hold),
    .timer_unit_mins(timer_unit_mins), .timer_unit_secs(timer_unit_secs),
    .timer_unit_decs(timer_unit_decs), .timer_running(timer_running),
    .timer_expired(timer_expired), .timer_expired_pulse(timer_expired_pulse)
  );

  always #5 CLK_100Hz = ~CLK_100Hz;

  typedef struct {
    int         stamp;
    string      name;
    logic [6:0] m;
    logic [5:0] s;
    logic [6:0] d;
    logic       r, e, p;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_cnt = 0;

  // Monitor: compares every expectation stamped for the edge just taken.
  always @(posedge CLK_100Hz) begin
    cyc++;
    #1;
    if (timer_expired_pulse) pulse_cnt++;
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      exp_t x;
      x = q.pop_front();
      n_checks++;
      if (x.stamp != cyc || timer_unit_mins != x.m || timer_unit_secs != x.s ||
          timer_unit_decs != x.d || timer_running != x.r ||
          timer_expired != x.e || timer_expired_pulse != x.p) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got %0d:%0d.%0d run=%0b exp=%0b pul=%0b, need %0d:%0d.%0d run=%0b exp=%0b pul=%0b (stamp %0d)",
                 x.name, cyc, timer_unit_mins, timer_unit_secs, timer_unit_decs,
                 timer_running, timer_expired, timer_expired_pulse,
                 x.m, x.s, x.d, x.r, x.e, x.p, x.stamp);
      end else begin
        $display("check %s cyc=%0d: %0d:%0d.%0d run=%0b exp=%0b pul=%0b ok",
                 x.name, cyc, x.m, x.s, x.d, x.r, x.e, x.p);
      end
    end
  end

  // Expectation for the state after the next rising edge.
  task automatic chk(input string name, input int m, input int s, input int d,
                     input bit r, input bit e, input bit p);
    exp_t x;
    x.stamp = cyc + 1;
    x.name = name;
    x.m = 7'(m); x.s = 6'(s); x.d = 7'(d);
    x.r = r; x.e = e; x.p = p;
    q.push_back(x);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK_100Hz);
  endtask

  task automatic set_load(input int m, input int s, input int d);
    load = 1'b1;
    load_mins = 7'(m); load_secs = 6'(s); load_decs = 7'(d);
  endtask

  initial begin
    int p0;
    tick(2);
    chk("reset", 0, 0, 0, 0, 0, 0); tick();
    reset = 1'b0;

    // Short countdown to expiry
    set_load(0, 0, 5); start_stop = 1'b1;
    chk("load_5", 0, 0, 5, 0, 0, 0); tick();
    load = 1'b0;
    chk("run_enter", 0, 0, 5, 1, 0, 0); tick();
    for (int k = 4; k >= 1; k--) begin
      chk("count_down", 0, 0, k, 1, 0, 0); tick();
    end
    chk("expire", 0, 0, 0, 0, 1, 1); tick();
    chk("expired_sticky", 0, 0, 0, 0, 1, 0); tick();
    chk("expired_ignores_run", 0, 0, 0, 0, 1, 0); tick();

    // Borrow chain
    set_load(1, 0, 0);
    chk("load_1min", 1, 0, 0, 0, 0, 0); tick();
    load = 1'b0;
    chk("run_1min", 1, 0, 0, 1, 0, 0); tick();
    chk("borrow_mins", 0, 59, 99, 1, 0, 0); tick();
    tick(99);
    chk("borrow_secs", 0, 58, 99, 1, 0, 0); tick();
    start_stop = 1'b0;
    chk("pause_keep", 0, 58, 99, 0, 0, 0); tick();

    // Saturation and zero load
    set_load(120, 63, 127);
    chk("saturate", 99, 59, 99, 0, 0, 0); tick();
    set_load(0, 0, 0); start_stop = 1'b1;
    chk("load_zero", 0, 0, 0, 0, 0, 0); tick();
    load = 1'b0;
    chk("idle_no_run", 0, 0, 0, 0, 0, 0); tick();
    chk("idle_no_run2", 0, 0, 0, 0, 0, 0); tick();
    start_stop = 1'b0;

    // Pause, hold and load ignored while running
    set_load(0, 10, 0);
    chk("load_10s", 0, 10, 0, 0, 0, 0); tick();
    load = 1'b0; start_stop = 1'b1;
    chk("run_10s", 0, 10, 0, 1, 0, 0); tick();
    tick(49);
    chk("after_50", 0, 9, 50, 1, 0, 0); tick();
    start_stop = 1'b0;
    chk("paused", 0, 9, 50, 0, 0, 0); tick();
    tick(18);
    chk("still_paused", 0, 9, 50, 0, 0, 0); tick();
    start_stop = 1'b1;
    chk("resume", 0, 9, 50, 1, 0, 0); tick();
    hold = 1'b1;
    chk("hold_first", 0, 9, 50, 1, 0, 0); tick();
    tick(28);
    chk("hold_last", 0, 9, 50, 1, 0, 0); tick();
    hold = 1'b0;
    chk("hold_release", 0, 9, 19, 1, 0, 0); tick();
    set_load(0, 30, 0);
    chk("load_in_run", 0, 9, 18, 1, 0, 0); tick();
    load = 1'b0;
    chk("after_load_run", 0, 9, 17, 1, 0, 0); tick();
    tick(379);
    chk("pre_reset", 0, 5, 37, 1, 0, 0); tick();

    // Reset mid-run, with a competing load
    reset = 1'b1; set_load(0, 30, 0);
    chk("reset_mid_run", 0, 0, 0, 0, 0, 0); tick();
    reset = 1'b0; load = 1'b0;
    chk("idle_after_reset", 0, 0, 0, 0, 0, 0); tick();

    // Expire, then reload clears the flag and a second run expires once
    set_load(0, 0, 2);
    chk("load_2", 0, 0, 2, 0, 0, 0); tick();
    load = 1'b0;
    chk("run_2", 0, 0, 2, 1, 0, 0); tick();
    chk("dec_1", 0, 0, 1, 1, 0, 0); tick();
    chk("expire_2", 0, 0, 0, 0, 1, 1); tick();
    set_load(0, 2, 0);
    chk("reload_clears", 0, 2, 0, 0, 0, 0); tick();
    load = 1'b0;
    p0 = pulse_cnt;
    chk("run_200", 0, 2, 0, 1, 0, 0); tick();
    tick(198);
    chk("last_tick", 0, 0, 1, 1, 0, 0); tick();
    chk("expire_200", 0, 0, 0, 0, 1, 1); tick();
    chk("expired_hold", 0, 0, 0, 0, 1, 0); tick();
    tick(2);
    n_checks++;
    if (pulse_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL pulse_count: got %0d pulses, need 1", pulse_cnt - p0);
    end else begin
      $display("check pulse_count: 1 pulse ok");
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
